// File: rtl/fetch_ctrl.sv
// Fetch stage of the pipelined MIPS core: PC register, IF/ID pipeline register,
// single-source interrupt entry/return and RUN-state performance counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h0000_0800,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              jump_rst,
    input  logic [31:0]       pc_in,
    input  logic              eret,
    input  logic              stall,
    input  logic              irq_req,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       pc_id,
    output logic [31:0]       instr_id,
    output logic              valid_id,
    output logic              irq_ack,
    output logic              halted,
    output logic [31:0]       epc,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       stall_cnt
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic        valid_id_q, valid_id_d;
    logic [31:0] epc_q, epc_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_ack_q, irq_ack_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // One-hot decode of the per-edge action; earlier entries mask later ones.
    logic in_run;
    logic take_halt;
    logic take_irq;
    logic take_jump;
    logic take_eret;
    logic take_stall;
    logic take_fetch;

    assign in_run     = (state_q == S_RUN);
    assign take_halt  = in_run & halt;
    assign take_irq   = in_run & ~halt & irq_req & irq_en_q & ~stall & ~eret;
    assign take_jump  = in_run & ~halt & ~take_irq & jump_rst;
    assign take_eret  = in_run & ~halt & ~take_irq & ~jump_rst & eret;
    assign take_stall = in_run & ~halt & ~take_irq & ~jump_rst & ~eret & stall;
    assign take_fetch = in_run & ~halt & ~take_irq & ~jump_rst & ~eret & ~stall;

    // Counts every RUN edge, including the one that enters HALT.
    assign cycle_cnt_d = in_run ? cycle_cnt_q + 32'd1 : cycle_cnt_q;

    always_comb begin
        // NOTE: every signal assigned here gets a hold default first, so no
        // path through the priority chain can leave one unassigned (no latch).
        state_d     = state_q;
        pc_d        = pc_q;
        pc_id_d     = pc_id_q;
        instr_id_d  = instr_id_q;
        valid_id_d  = valid_id_q;
        epc_d       = epc_q;
        irq_en_d    = irq_en_q;
        irq_ack_d   = 1'b0;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (take_halt) begin
            valid_id_d = 1'b0;
            state_d    = S_HALT;
        end else if (take_irq) begin
            // A redirect in the same cycle is the correct return point.
            epc_d      = jump_rst ? pc_in : pc_q;
            pc_d       = IRQ_VEC;
            valid_id_d = 1'b0;
            irq_en_d   = 1'b0;
            irq_ack_d  = 1'b1;
            if (jump_rst) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end else if (take_jump) begin
            pc_d        = pc_in;
            valid_id_d  = 1'b0;
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else if (take_eret) begin
            pc_d       = epc_q;
            valid_id_d = 1'b0;
            irq_en_d   = 1'b1;
        end else if (take_stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else if (take_fetch) begin
            pc_id_d    = pc_q;
            instr_id_d = imem_data;
            valid_id_d = 1'b1;
            pc_d       = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_PC;
            pc_id_q     <= 32'd0;
            instr_id_q  <= 32'd0;
            valid_id_q  <= 1'b0;
            epc_q       <= 32'd0;
            irq_en_q    <= 1'b1;
            irq_ack_q   <= 1'b0;
            cycle_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_id_q     <= pc_id_d;
            instr_id_q  <= instr_id_d;
            valid_id_q  <= valid_id_d;
            epc_q       <= epc_d;
            irq_en_q    <= irq_en_d;
            irq_ack_q   <= irq_ack_d;
            cycle_cnt_q <= cycle_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign imem_addr = pc_q[ADDR_W+1:2];
    assign pc_id     = pc_id_q;
    assign instr_id  = instr_id_q;
    assign valid_id  = valid_id_q;
    assign irq_ack   = irq_ack_q;
    assign halted    = (state_q == S_HALT);
    assign epc       = epc_q;
    assign cycle_cnt = cycle_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- PC register and IF/ID pipeline register for the pipelined MIPS core.
- Consumes the redirect interface driven by the execute stage: `jump_rst`, `pc_in`, `halt` and `eret`.
- Also consumes the load-use stall from hazard detection and a single-source interrupt request.
- Drives the instruction-memory address and the fetched instruction/PC into decode, and keeps performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IRQ_VEC, 32'h0000_0800, interrupt entry address.
- ADDR_W, 10, instruction-memory word-address width.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- halt  in  1  execute stage holds a halt (syscall-exit) instruction
- jump_rst  in  1  execute stage redirect (j/jr/jal/taken branch)
- pc_in  in  32  redirect target, valid when jump_rst=1
- eret  in  1  execute stage holds interrupt return
- stall  in  1  load-use stall from hazard detection
- irq_req  in  1  level interrupt request
- imem_data  in  32  instruction at imem_addr, combinational read
- imem_addr  out  ADDR_W  pc[ADDR_W+1:2]
- pc_id  out  32  PC of instruction in IF/ID
- instr_id  out  32  instruction in IF/ID
- valid_id  out  1  IF/ID holds a live instruction
- irq_ack  out  1  one-cycle pulse, interrupt accepted
- halted  out  1  core in HALT state
- epc  out  32  saved return address
- cycle_cnt  out  32  cycles spent in RUN
- flush_cnt  out  32  IF/ID flushes caused by jump_rst
- stall_cnt  out  32  stall cycles honoured

Behaviour:
- Reset (rst=1 at edge), overrides everything:
  - pc=RESET_PC; pc_id=0, instr_id=0, valid_id=0.
  - epc=0; internal irq_en=1; irq_ack=0.
  - state=RUN, halted=0; all counters 0.
- States: RUN, HALT. RUN->HALT when halt=1. HALT is sticky until rst. halted=(state==HALT).
- Per-edge priority while in RUN, first match wins:
  - 1. halt: pc holds; valid_id<=0; enter HALT.
  - 2. irq accept, when irq_req & irq_en & ~stall & ~eret:
    - epc <= jump_rst ? pc_in : pc.
    - pc <= IRQ_VEC; valid_id<=0; irq_en<=0; irq_ack<=1.
    - If jump_rst is also high, still increment flush_cnt.
  - 3. jump_rst: pc<=pc_in; valid_id<=0; flush_cnt++. Overrides stall, because the stalled instruction is on the wrong path.
  - 4. eret: pc<=epc; valid_id<=0; irq_en<=1. If eret and jump_rst are high together, jump_rst wins (item 3) and eret is ignored (protocol error).
  - 5. stall: pc, pc_id, instr_id, valid_id all hold; stall_cnt++.
  - 6. normal: pc_id<=pc; instr_id<=imem_data; valid_id<=1; pc<=pc+4.
- irq_ack is 0 on every edge where item 2 does not fire.
- A flush (items 1-4) leaves pc_id/instr_id at their old values; only valid_id is cleared.
- cycle_cnt increments on every RUN edge, including the edge entering HALT.
- HALT state: pc, IF/ID and counters are frozen; all inputs except rst are ignored.
- Latency:
  - Redirect target appears on imem_addr one cycle after jump_rst.
  - First target instruction has valid_id=1 two cycles after jump_rst.
- Arithmetic:
  - pc+4 wraps modulo 2^32.
  - Counters wrap 32'hFFFF_FFFF -> 0.
  - pc[1:0] is not checked; imem_addr drops those bits.
- irq_req is level-sensitive. While irq_en=0 it is ignored (no nesting); it is re-evaluated after eret.

Test Plan:
- Reset then 4 free-running cycles with imem returning addr-tagged words:
  - pc_id sequence 0,4,8 with valid_id=1 from cycle 2.
  - cycle_cnt=4, other counters 0.
- At pc=0x10 assert jump_rst=1, pc_in=0x40 for one cycle, with stall=1 in the same cycle:
  - next cycle imem_addr=0x10, valid_id=0, flush_cnt=1, stall_cnt=0.
  - following cycle pc_id=0x40, valid_id=1.
- Hold stall=1 for 3 cycles at pc=0x20:
  - pc, pc_id, instr_id unchanged, stall_cnt=3.
  - after release, pc_id=0x20 then 0x24.
- irq_req=1 at pc=0x30 with jump_rst=1, pc_in=0x80 in the same cycle:
  - irq_ack pulses 1 cycle, epc=0x80, next fetch 0x800, flush_cnt+1.
  - holding irq_req=1 gives no second ack.
  - eret -> fetch 0x80; irq_req still high -> second ack one edge after the eret redirect.
- halt=1 together with jump_rst=1 at pc=0x50:
  - halted=1, pc stays 0x50, valid_id=0, flush_cnt unchanged.
  - 10 further cycles of stimulus change nothing.
  - rst=1 -> pc=0, halted=0.
- Preload cycle_cnt near wrap (run 2^32-2 cycles via force or long sim): 3 more cycles -> cycle_cnt=1.
